// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle accumulator-CPU controller:
// opcodes, accumulator source selects and the sequencer state enum.
package multicycle_controller_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_ADD     = 4'b0001;
  localparam logic [3:0] OP_SUB     = 4'b0010;
  localparam logic [3:0] OP_NOR     = 4'b0011;
  localparam logic [3:0] OP_REG2ACC = 4'b0100;
  localparam logic [3:0] OP_ACC2REG = 4'b0101;
  localparam logic [3:0] OP_JZR     = 4'b0110;
  localparam logic [3:0] OP_JZI     = 4'b0111;
  localparam logic [3:0] OP_JCR     = 4'b1000;
  localparam logic [3:0] OP_JMPR    = 4'b1001;
  localparam logic [3:0] OP_JCI     = 4'b1010;
  localparam logic [3:0] OP_SHL     = 4'b1011;
  localparam logic [3:0] OP_SHR     = 4'b1100;
  localparam logic [3:0] OP_IMM2ACC = 4'b1101;
  localparam logic [3:0] OP_JMPI    = 4'b1110;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam logic [1:0] SELACC_IMM = 2'b00;
  localparam logic [1:0] SELACC_ALU = 2'b01;
  localparam logic [1:0] SELACC_REG = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle controller: FETCH/DECODE/EXEC sequencing with fetch handshake,
// fetch-timeout fault, resumable HALT and a wrapping retired-instruction count.
//
// state  | meaning
// FETCH  | IFetchReq high, wait for IFetchAck or time out
// DECODE | opcode settles on SelALU, no strobes
// EXEC   | one cycle of datapath strobes, retire the instruction
// HALT   | parked until Resume, which bumps the PC
// FAULT  | fetch timed out; sticky until CLB
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int SELALU_W      = 4,
  parameter int FETCH_TIMEOUT = 15,
  parameter int RETIRE_W      = 16
) (
  input  logic                CLK,
  input  logic                CLB,
  input  logic                Z,
  input  logic                C,
  input  logic [3:0]          Opcode,
  input  logic                IFetchAck,
  input  logic                Resume,
  output logic                IFetchReq,
  output logic                LoadIR,
  output logic                IncPC,
  output logic                SelPC,
  output logic                LoadPC,
  output logic                LoadReg,
  output logic                LoadAcc,
  output logic [1:0]          SelAcc,
  output logic [SELALU_W-1:0] SelALU,
  output logic                LoadFlags,
  output logic                Halted,
  output logic                Fault,
  output logic [RETIRE_W-1:0] RetireCount
);

  localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  always_ff @(posedge CLK) begin
    if (!CLB) begin
      state_q  <= ST_FETCH;
      wait_q   <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    retire_d    = retire_q;
    IFetchReq   = 1'b0;
    LoadIR      = 1'b0;
    IncPC       = 1'b0;
    SelPC       = 1'b0;
    LoadPC      = 1'b0;
    LoadReg     = 1'b0;
    LoadAcc     = 1'b0;
    SelAcc      = SELACC_IMM;
    SelALU      = '0;
    LoadFlags   = 1'b0;
    Halted      = 1'b0;
    Fault       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        IFetchReq = 1'b1;
        if (IFetchAck) begin
          LoadIR  = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        SelALU  = SELALU_W'(Opcode);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // ALU op stays on SelALU so the result captured this cycle is valid
        SelALU   = SELALU_W'(Opcode);
        retire_d = retire_q + 1'b1;
        state_d  = ST_FETCH;
        case (Opcode)
          OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
            LoadAcc   = 1'b1;
            SelAcc    = SELACC_ALU;
            LoadFlags = 1'b1;
            IncPC     = 1'b1;
          end
          OP_REG2ACC: begin
            LoadAcc = 1'b1;
            SelAcc  = SELACC_REG;
            IncPC   = 1'b1;
          end
          OP_ACC2REG: begin
            LoadReg = 1'b1;
            IncPC   = 1'b1;
          end
          OP_IMM2ACC: begin
            LoadAcc = 1'b1;
            SelAcc  = SELACC_IMM;
            IncPC   = 1'b1;
          end
          OP_JZR, OP_JZI: begin
            LoadPC = Z;
            SelPC  = Z & (Opcode == OP_JZI);
            IncPC  = ~Z;
          end
          OP_JCR, OP_JCI: begin
            LoadPC = C;
            SelPC  = C & (Opcode == OP_JCI);
            IncPC  = ~C;
          end
          OP_JMPR: LoadPC = 1'b1;
          OP_JMPI: begin
            LoadPC = 1'b1;
            SelPC  = 1'b1;
          end
          OP_HALT: state_d = ST_HALT;
          default: IncPC = 1'b1;
        endcase
      end
      ST_HALT: begin
        Halted = 1'b1;
        if (Resume) begin
          IncPC   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FAULT: Fault = 1'b1;
      default:  state_d = ST_FETCH;
    endcase

    // Reset is synchronous, but the outputs must read zero for the whole
    // cycle CLB is low, including the aborted cycle itself.
    if (!CLB) begin
      IFetchReq = 1'b0;
      LoadIR    = 1'b0;
      IncPC     = 1'b0;
      SelPC     = 1'b0;
      LoadPC    = 1'b0;
      LoadReg   = 1'b0;
      LoadAcc   = 1'b0;
      SelAcc    = 2'b00;
      SelALU    = '0;
      LoadFlags = 1'b0;
      Halted    = 1'b0;
      Fault     = 1'b0;
    end
  end

  assign RetireCount = CLB ? retire_q : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: random instruction streams against an instruction-level
// model of strobes, latency, timeout, HALT/Resume and retire counting.
module tb_multicycle_controller;

  localparam int TIMEOUT = 4;
  localparam int RW      = 4;

  logic          CLK = 1'b0;
  logic          CLB = 1'b0;
  logic          Z = 1'b0, C = 1'b0;
  logic [3:0]    Opcode = 4'd0;
  logic          IFetchAck = 1'b0, Resume = 1'b0;
  logic          IFetchReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]    SelAcc;
  logic [3:0]    SelALU;
  logic          LoadFlags, Halted, Fault;
  logic [RW-1:0] RetireCount;

  multicycle_controller #(.SELALU_W(4), .FETCH_TIMEOUT(TIMEOUT), .RETIRE_W(RW)) dut (
    .CLK(CLK), .CLB(CLB), .Z(Z), .C(C), .Opcode(Opcode),
    .IFetchAck(IFetchAck), .Resume(Resume),
    .IFetchReq(IFetchReq), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
    .SelALU(SelALU), .LoadFlags(LoadFlags), .Halted(Halted), .Fault(Fault),
    .RetireCount(RetireCount)
  );

  always #5 CLK = ~CLK;

  // [11]IFetchReq [10]LoadIR [9]IncPC [8]SelPC [7]LoadPC [6]LoadReg
  // [5]LoadAcc [4:3]SelAcc [2]LoadFlags [1]Halted [0]Fault
  logic [11:0] obs;
  assign obs = {IFetchReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg,
                LoadAcc, SelAcc, LoadFlags, Halted, Fault};

  localparam logic [11:0] V_REQ    = 12'h800;
  localparam logic [11:0] V_LIR    = 12'h400;
  localparam logic [11:0] V_INC    = 12'h200;
  localparam logic [11:0] V_SELPC  = 12'h100;
  localparam logic [11:0] V_LDPC   = 12'h080;
  localparam logic [11:0] V_LDREG  = 12'h040;
  localparam logic [11:0] V_LDACC  = 12'h020;
  localparam logic [11:0] V_ACCALU = 12'h008;
  localparam logic [11:0] V_ACCREG = 12'h010;
  localparam logic [11:0] V_FLAGS  = 12'h004;
  localparam logic [11:0] V_HALTED = 12'h002;
  localparam logic [11:0] V_FAULT  = 12'h001;

  int checks   = 0;
  int failures = 0;
  int retire_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected EXEC strobes from the instruction's meaning.
  function automatic logic [11:0] exec_strobes(input logic [3:0] op, input logic z, input logic c);
    logic [11:0] v;
    logic is_jmp, cond_jz, cond_jc, imm_target, taken;
    is_jmp     = (op == 4'd9) || (op == 4'd14);
    cond_jz    = (op == 4'd6) || (op == 4'd7);
    cond_jc    = (op == 4'd8) || (op == 4'd10);
    imm_target = (op == 4'd7) || (op == 4'd10) || (op == 4'd14);
    taken      = is_jmp || (cond_jz && z) || (cond_jc && c);
    v = '0;
    if (taken)                 v = V_LDPC | (imm_target ? V_SELPC : 12'h0);
    else if (op != 4'd15)      v = V_INC;
    if (op inside {4'd1, 4'd2, 4'd3, 4'd11, 4'd12}) v |= V_LDACC | V_ACCALU | V_FLAGS;
    if (op == 4'd4)            v |= V_LDACC | V_ACCREG;
    if (op == 4'd13)           v |= V_LDACC;
    if (op == 4'd5)            v |= V_LDREG;
    return v;
  endfunction

  task automatic run_instr(input logic [3:0] op, input int waits, input logic z, input logic c);
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      CLB = 1'b1; IFetchAck = 1'b0; Resume = $urandom;
      Z = $urandom; C = $urandom; Opcode = 4'($urandom);
      #1;
      check("fetch_wait", 32'(obs), 32'(V_REQ));
      check("retire_fetch", 32'(RetireCount), 32'(retire_m));
    end
    @(negedge CLK);
    CLB = 1'b1; IFetchAck = 1'b1; Resume = 1'b0;
    #1;
    check("fetch_ack", 32'(obs), 32'(V_REQ | V_LIR));
    check("retire_fetch", 32'(RetireCount), 32'(retire_m));
    @(negedge CLK);
    IFetchAck = $urandom; Opcode = op; Z = $urandom; C = $urandom;
    #1;
    check("decode", 32'(obs), 32'h0);
    check("selalu", 32'(SelALU), 32'(op));
    @(negedge CLK);
    IFetchAck = $urandom; Z = z; C = c;
    #1;
    check($sformatf("exec_op%0h_z%0d_c%0d", op, z, c), 32'(obs), 32'(exec_strobes(op, z, c)));
    retire_m = (retire_m + 1) % (1 << RW);
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      CLB = 1'b0; IFetchAck = $urandom; Resume = $urandom; Opcode = 4'($urandom);
      #1;
      check("reset_outs", 32'(obs), 32'h0);
      check("reset_selalu", 32'(SelALU), 32'h0);
      check("reset_retire", 32'(RetireCount), 32'h0);
    end
    retire_m = 0;
  endtask

  initial begin
    hold_reset(3);

    run_instr(4'd1, 0, 1'b0, 1'b0);
    @(negedge CLK);
    IFetchAck = 1'b0; #1;
    check("first_retire", 32'(RetireCount), 32'd1);
    check("fetch_after_exec", 32'(obs), 32'(V_REQ));

    hold_reset(1);
    run_instr(4'd6, 0, 1'b1, 1'b0);
    run_instr(4'd6, 0, 1'b0, 1'b1);
    run_instr(4'd10, 0, 1'b0, 1'b1);
    run_instr(4'd10, 0, 1'b1, 1'b0);
    run_instr(4'd3, TIMEOUT - 1, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr(op, $urandom_range(0, TIMEOUT - 1), 1'($urandom), 1'($urandom));
    end

    // HALT: parked 10 cycles, Resume pulses IncPC, then straight back to FETCH
    run_instr(4'd15, 1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      Resume = 1'b0; IFetchAck = $urandom; Z = $urandom; C = $urandom;
      #1;
      check("halted", 32'(obs), 32'(V_HALTED));
      check("retire_halt", 32'(RetireCount), 32'(retire_m));
    end
    @(negedge CLK);
    Resume = 1'b1; #1;
    check("resume", 32'(obs), 32'(V_HALTED | V_INC));
    run_instr(4'd0, 0, 1'b0, 1'b0);

    // retire counter wraps at 2^RW
    hold_reset(1);
    for (int i = 0; i < 17; i++) run_instr(4'd0, 0, 1'b0, 1'b0);
    @(negedge CLK);
    IFetchAck = 1'b0; #1;
    check("retire_wrap", 32'(RetireCount), 32'd1);

    // reset during EXEC of ACC->REG aborts with no strobes
    hold_reset(1);
    run_instr(4'd2, 0, 1'b0, 1'b0);
    @(negedge CLK);
    CLB = 1'b1; IFetchAck = 1'b1; #1;
    check("abort_fetch", 32'(obs), 32'(V_REQ | V_LIR));
    @(negedge CLK);
    IFetchAck = 1'b0; Opcode = 4'd5; #1;
    check("abort_decode", 32'(obs), 32'h0);
    @(negedge CLK);
    CLB = 1'b0; #1;
    check("abort_loadreg", 32'(LoadReg), 32'h0);
    check("abort_outs", 32'(obs), 32'h0);
    check("abort_retire", 32'(RetireCount), 32'h0);
    retire_m = 0;
    run_instr(4'd13, 0, 1'b0, 1'b0);

    // timeout: no ack for TIMEOUT cycles -> sticky fault
    hold_reset(1);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge CLK);
      CLB = 1'b1; IFetchAck = 1'b0; #1;
      check("timeout_fetch", 32'(obs), 32'(V_REQ));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      IFetchAck = $urandom; Resume = $urandom; Z = $urandom; C = $urandom; #1;
      check("fault_sticky", 32'(obs), 32'(V_FAULT));
    end
    hold_reset(2);
    run_instr(4'd14, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle accumulator-CPU controller: it sequences each instruction through FETCH, DECODE and EXECUTE states and waits on a fetch handshake with instruction memory. It adds unconditional jumps, a resumable HALT, a fetch-timeout fault and a retired-instruction counter. It sits between the instruction register/PC datapath and the ALU/accumulator, and drives all datapath load and select strobes.

## Interface
- SELALU_W, 4, width of SelALU (opcode zero-extended or truncated to fit)
- FETCH_TIMEOUT, 15, max wait cycles in FETCH without IFetchAck before fault (≥1)
- RETIRE_W, 16, width of RetireCount
- Clocking: one clock, CLK; reset CLB is synchronous and active-low.
- CLK  in  1  clock, rising edge
- CLB  in  1  synchronous active-low reset
- Z  in  1  accumulator-zero flag, from flag register
- C  in  1  carry/negative flag, from flag register
- Opcode  in  4  IR[opcode], valid from DECODE onward
- IFetchAck  in  1  instruction memory data valid this cycle
- Resume  in  1  leave HALT (level, sampled in HALT only)
- IFetchReq  out  1  fetch request, high throughout FETCH
- LoadIR  out  1  capture instruction
- IncPC  out  1  PC ← PC+1
- SelPC  out  1  0 = register source, 1 = immediate source
- LoadPC  out  1  PC ← selected branch target
- LoadReg  out  1  register ← ACC
- LoadAcc  out  1  ACC ← SelAcc source
- SelAcc  out  2  00 = immediate, 01 = ALU, 10 = register
- SelALU  out  SELALU_W  ALU operation
- LoadFlags  out  1  flag register ← ALU Z/C
- Halted  out  1  high in HALT
- Fault  out  1  sticky fetch-timeout fault
- RetireCount  out  RETIRE_W  retired instructions, wraps

## Operation
- States: FETCH, DECODE, EXEC, HALT, FAULT. Encode as a one-hot or binary enum.
- FETCH: IFetchReq=1. When IFetchAck=1, assert LoadIR=1 in the same cycle and go to DECODE. Otherwise increment the wait counter. If the counter reaches FETCH_TIMEOUT without an ack, go to FAULT.
- DECODE: all strobes 0; SelALU=Opcode. Go to EXEC.
- EXEC: assert strobes for one cycle, per opcode:
  - 0000 NOP: IncPC.
  - 0001 ADD, 0010 SUB, 0011 NOR, 1011 SHL, 1100 SHR: LoadAcc, SelAcc=01, LoadFlags, IncPC.
  - 0100 REG→ACC: LoadAcc, SelAcc=10, IncPC.
  - 0101 ACC→REG: LoadReg, IncPC.
  - 1101 IMM→ACC: LoadAcc, SelAcc=00, IncPC.
  - 0110 JZ reg: if Z=1 then LoadPC, SelPC=0; else IncPC.
  - 0111 JZ imm: if Z=1 then LoadPC, SelPC=1; else IncPC.
  - 1000 JC reg: if C=1 then LoadPC, SelPC=0; else IncPC.
  - 1010 JC imm: if C=1 then LoadPC, SelPC=1; else IncPC.
  - 1001 JMP reg: LoadPC, SelPC=0.
  - 1110 JMP imm: LoadPC, SelPC=1.
  - 1111 HALT: no strobes; go to HALT.
- LoadPC and IncPC are never asserted together.
- EXEC goes to FETCH for every opcode except HALT.
- RetireCount increments on every EXEC cycle, HALT included. It wraps from all-ones to 0.
- HALT: Halted=1, all strobes 0. When Resume=1: IncPC=1 in that cycle, then go to FETCH.
- FAULT: Fault=1, all strobes 0. Only CLB exits FAULT.
- Z and C are sampled only in EXEC.

## Timing
- Reset (CLB=0 at a rising edge): state←FETCH, wait counter←0, RetireCount←0.
- While CLB=0, every output is 0, including IFetchReq, Halted and Fault.
- IFetchReq is 1 in the first cycle after CLB is released.
- Latency with ack in the first FETCH cycle: 3 cycles per instruction (FETCH, DECODE, EXEC). Each FETCH wait cycle adds 1.
- Wait counter clears on entry to FETCH.
- Fault timing: with FETCH_TIMEOUT=N and no ack, FETCH lasts exactly N cycles and Fault=1 from the following cycle.
- An ack in cycle N counts as a normal fetch; there is no fault.
- Strobes are Moore outputs decoded from state, Opcode and flags. The only Mealy outputs are LoadIR (from IFetchAck in FETCH) and IncPC (from Resume in HALT).
- CLB=0 mid-instruction aborts at the next edge; no strobe is asserted in that cycle.

## Structure
- Shared package: opcode constants (OP_NOP … OP_HALT), SelAcc encodings, state enum.
- Single module; no sub-module. The fetch-timeout counter is inline.

## Test plan
- Reset, then ack on the first FETCH cycle, Opcode=0001 → LoadIR at cycle 1, EXEC at cycle 3 with LoadAcc=1, SelAcc=01, LoadFlags=1, IncPC=1; RetireCount=1.
- Opcode=0110: with Z=1 → LoadPC=1, SelPC=0, IncPC=0; with Z=0 → IncPC=1, LoadPC=0. Repeat for 1010 with C.
- FETCH_TIMEOUT=4:
  - Ack withheld 3 cycles, then given → normal decode, Fault=0.
  - Ack withheld 4 cycles → Fault=1 and stays 1 regardless of ack, until CLB.
- Opcode=1111 → Halted=1 for 10 cycles with no strobes. Resume=1 → IncPC pulse, then IFetchReq=1 the next cycle.
- Preload near wrap with RETIRE_W=4: run 17 NOPs → RetireCount=1.
- CLB=0 during EXEC of 0101 → LoadReg=0 that cycle and all outputs 0; after release, FETCH with RetireCount=0.
